// File: rtl/sev_segment_mux_drvr.sv
// Time-multiplexed seven-segment driver with frame-synchronous double buffering of display data.
// Optional leading-zero suppression (adds lz_blank_in) is enabled by defining SEV_SEG_LZ_BLANK_EN.
module sev_segment_mux_drvr #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] hex_digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load_in,
`ifdef SEV_SEG_LZ_BLANK_EN
  input  logic                    lz_blank_in,
`endif
  output logic [6:0]              ss_pattern_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en_out,
  output logic [IDX_W-1:0]        digit_idx_out,
  output logic                    frame_start_out
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] LAST_PRESC = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  // Hex nibble to {a,b,c,d,e,f,g}, a in bit 6.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h73;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      4'hF:    seg = 7'h47;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PRE_W-1:0]        presc_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    first_r;
  logic                    pend_valid_r;
  logic [4*NUM_DIGITS-1:0] pend_hex_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blank_r;
  logic [4*NUM_DIGITS-1:0] disp_hex_r;
  logic [NUM_DIGITS-1:0]   disp_dp_r;
  logic [NUM_DIGITS-1:0]   disp_blank_r;
`ifdef SEV_SEG_LZ_BLANK_EN
  logic                    pend_lz_r;
  logic                    disp_lz_r;
  logic                    lz_run_s;
`endif

  logic                    presc_wrap_s;
  logic                    boundary_s;
  logic [NUM_DIGITS-1:0]   eff_blank_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [3:0]              cur_hex_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;

  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   digit_en_r;
  logic [IDX_W-1:0]        digit_idx_r;
  logic                    frame_start_r;

  // Slot wrap and frame boundary detection (first cycle after reset also counts as a boundary).
  always_comb begin
    presc_wrap_s = (presc_r == LAST_PRESC);
    boundary_s   = first_r | (presc_wrap_s & (idx_r == LAST_IDX));
  end

  // Refresh prescaler, digit index and the pending/display double buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r      <= {PRE_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      first_r      <= 1'b1;
      pend_valid_r <= 1'b0;
      pend_hex_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_blank_r <= {NUM_DIGITS{1'b0}};
      disp_hex_r   <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r    <= {NUM_DIGITS{1'b0}};
      disp_blank_r <= {NUM_DIGITS{1'b1}};
`ifdef SEV_SEG_LZ_BLANK_EN
      pend_lz_r    <= 1'b0;
      disp_lz_r    <= 1'b0;
`endif
    end else begin
      first_r <= 1'b0;
      if (presc_wrap_s) begin
        presc_r <= {PRE_W{1'b0}};
        idx_r   <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end else begin
        presc_r <= presc_r + PRE_W'(1);
      end

      // A load landing on the boundary goes straight to the display and supersedes pending data.
      if (boundary_s && load_in) begin
        disp_hex_r   <= hex_digits_in;
        disp_dp_r    <= dp_in;
        disp_blank_r <= blank_in;
`ifdef SEV_SEG_LZ_BLANK_EN
        disp_lz_r    <= lz_blank_in;
`endif
        pend_valid_r <= 1'b0;
      end else if (boundary_s && pend_valid_r) begin
        disp_hex_r   <= pend_hex_r;
        disp_dp_r    <= pend_dp_r;
        disp_blank_r <= pend_blank_r;
`ifdef SEV_SEG_LZ_BLANK_EN
        disp_lz_r    <= pend_lz_r;
`endif
        pend_valid_r <= 1'b0;
      end else if (load_in) begin
        pend_hex_r   <= hex_digits_in;
        pend_dp_r    <= dp_in;
        pend_blank_r <= blank_in;
`ifdef SEV_SEG_LZ_BLANK_EN
        pend_lz_r    <= lz_blank_in;
`endif
        pend_valid_r <= 1'b1;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  // Effective blanking and selection of the digit currently being driven.
  always_comb begin
    eff_blank_s = disp_blank_r;
`ifdef SEV_SEG_LZ_BLANK_EN
    // Walk down from the top digit while everything seen so far is a zero nibble without dp.
    lz_run_s = disp_lz_r;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run_s       = lz_run_s & (disp_hex_r[4*k +: 4] == 4'h0) & ~disp_dp_r[k];
      eff_blank_s[k] = disp_blank_r[k] | (lz_run_s & (k > 0));
    end
`endif
    onehot_s    = {NUM_DIGITS{1'b0}};
    cur_hex_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      onehot_s[k] = (idx_r == IDX_W'(k));
      cur_hex_s   = onehot_s[k] ? disp_hex_r[4*k +: 4] : cur_hex_s;
      cur_dp_s    = onehot_s[k] ? disp_dp_r[k]         : cur_dp_s;
      cur_blank_s = onehot_s[k] ? eff_blank_s[k]       : cur_blank_s;
    end
  end

  // Output register stage: one cycle behind the index and display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r         <= 7'h00;
      dp_r          <= 1'b0;
      digit_en_r    <= {NUM_DIGITS{1'b0}};
      digit_idx_r   <= {IDX_W{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= cur_blank_s ? 7'h00 : seg_decode(cur_hex_s);
      dp_r          <= cur_dp_s & ~cur_blank_s;
      digit_en_r    <= onehot_s;
      digit_idx_r   <= idx_r;
      frame_start_r <= (idx_r == {IDX_W{1'b0}}) & (presc_r == {PRE_W{1'b0}});
    end
  end

  // Pin polarity is applied after the register so reset leaves every pin at its inactive level.
  assign ss_pattern_out  = (SEG_ACTIVE_LOW != 0) ? ~seg_r      : seg_r;
  assign dp_out          = (SEG_ACTIVE_LOW != 0) ? ~dp_r       : dp_r;
  assign digit_en_out    = (AN_ACTIVE_LOW != 0)  ? ~digit_en_r : digit_en_r;
  assign digit_idx_out   = digit_idx_r;
  assign frame_start_out = frame_start_r;

endmodule

// File: doc/sev_segment_mux_drvr.md
Name: sev_segment_mux_drvr

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode seven-segment digits. It shares one segment bus across all digits. Each digit is selected in turn for REFRESH_DIV clocks. It decodes hex nibbles with the team's standard {a,b,c,d,e,f,g} table and adds per-digit decimal point and blanking. New display data is double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
REFRESH_DIV, 1000, clocks each digit stays selected (>=1)
SEG_ACTIVE_LOW, 0, 1 inverts ss_pattern_out and dp_out at the pins
AN_ACTIVE_LOW, 0, 1 inverts digit_en_out at the pins

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
hex_digits_in  in  4*NUM_DIGITS  nibble k = bits [4k+3:4k]; digit 0 is least significant / rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
blank_in  in  NUM_DIGITS  force digit dark
load_in  in  1  single-cycle strobe; captures hex_digits_in/dp_in/blank_in
ss_pattern_out  out  7  {a,b,c,d,e,f,g}, registered
dp_out  out  1  decimal point segment, registered
digit_en_out  out  NUM_DIGITS  one-hot digit select, registered
digit_idx_out  out  max(1,$clog2(NUM_DIGITS))  index of digit currently driven, registered
frame_start_out  out  1  one-cycle pulse on the first output cycle of digit 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (logical, before polarity inversion):
  - ss_pattern_out=0, dp_out=0, digit_en_out=0, digit_idx_out=0, frame_start_out=0.
  - Prescaler=0, index=0, pending_valid=0.
  - Display register: digits=0, dp=0, blank=all ones, so the display is dark until the first commit.
- Reset asserted mid-frame aborts the frame immediately. Any pending load is discarded.
- Prescaler: counts 0..REFRESH_DIV-1. When it reaches REFRESH_DIV-1 it wraps to 0, and the index advances to index+1, or to 0 after NUM_DIGITS-1.
- REFRESH_DIV=1: the index advances every clock.
- NUM_DIGITS=1: the index stays 0 and every wrap is a frame boundary.
- Frame boundary: the cycle in which the index transitions NUM_DIGITS-1 -> 0, plus the first cycle after reset release.
- Load/commit:
  - load_in=1 captures all three inputs into the pending register and sets pending_valid.
  - A later load before commit overwrites pending (last wins).
  - At a frame boundary with pending_valid=1, the display register takes the pending values and pending_valid clears.
  - load_in coincident with a frame boundary writes the inputs straight into the display register, bypassing pending, and clears pending_valid.
- Output pipeline: outputs in cycle N+1 reflect index and display register in cycle N (one-cycle latency).
  - digit_en_out = one-hot(index).
  - frame_start_out = 1 in the first registered cycle where digit_idx_out becomes 0.
  - After reset release, digit_en_out[0] is asserted on the first clock.
- Decode: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:73 A:77 B:1F C:4E D:3D E:4F F:47 (hex in {a..g}, a = MSB).
- Blanked digit: ss_pattern_out=0 and dp_out=0; the digit enable is still asserted.
- Polarity: inversion is applied after registration. Reset levels are therefore the inactive pin levels.

Optional Feature:
SEV_SEG_LZ_BLANK_EN
- Defined: adds an input lz_blank_in (1 bit) that is captured with load_in.
- When the captured bit is 1, a digit k>0 is blanked if its nibble and every higher nibble are 0, and none of those digits has dp set.
- Digit 0 is never suppressed.
- Undefined: no port; digits are blanked only via blank_in.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4; release reset with no load -> digit_en_out cycles 0001,0010,0100,1000 in 4-clock slots; ss_pattern_out=0 throughout; frame_start_out pulses every 16 clocks.
- Load hex=0x1234 mid-frame -> no change until the next frame boundary. Then the digit 0 slot shows 0x33, digit 1 0x79, digit 2 0x6D, digit 3 0x30.
- Load 0xAAAA then 0x0F0F before the boundary -> only 0x0F0F is committed. Load coincident with the boundary -> that value shows in the same frame's digit 0 slot.
- dp_in=0101, blank_in=1000, hex=0x8888 -> dp_out=1 on digits 0 and 2; digit 3 has ss_pattern_out=0 with digit_en_out[3]=1.
- SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1; assert rst mid-frame -> next clock all pins read 1 and the index restarts at 0. A pending load is lost.
- SEV_SEG_LZ_BLANK_EN, lz_blank_in=1, hex=0x0050 -> digits 3 and 2 dark; digits 1 and 0 show 0x5B and 0x7E. hex=0x0000 -> only digit 0 shows 0x7E.
